alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides and a
// registered result plus Z/N/C/V flags. Every operation except multiply
// completes in one cycle.
// Optional feature: define ALU_MUL_EN to build the iterative shift-add
// multiplier (sel=8, WIDTH cycles). Without it, sel=8 behaves as add.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_PASS = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;

  // Result register and handshake state
  logic [WIDTH-1:0] out_q, out_d;
  logic             zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, vf_q, vf_d;
  logic             out_valid_q, out_valid_d;

  // Single-cycle ALU intermediates
  logic [SHW-1:0]        shamt;
  logic [WIDTH:0]        add_full, sub_full, shl_full, shr_full;
  logic signed [WIDTH:0] asr_full;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_cf, alu_vf;

  // Shared control between the single-cycle path and the multiplier
  logic             accept, drain, load_alu;
  logic             mul_sel, mul_load;
  logic [WIDTH-1:0] mul_res;
  logic             mul_cf;
  logic [WIDTH-1:0] res;
  logic             res_cf, res_vf;

  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign load_alu = accept && !mul_sel;
  assign shamt    = in2[SHW-1:0];

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] mul_final;
  logic               mul_start, mul_last;

  assign mul_sel   = (sel == OP_MUL);
  assign mul_start = accept && mul_sel;
  assign mul_last  = (state_q == MUL) && (cnt_q == CNT_LAST);
  assign mul_load  = mul_last;
  assign mul_res   = mul_final[WIDTH-1:0];
  assign mul_cf    = |mul_final[2*WIDTH-1:WIDTH];

  // FSM state register; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enter MUL on accepting a multiply, leave after the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall the input side and flag busy while multiplying
  always_comb begin
    busy     = (state_q == MUL);
    in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mul_final = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (mul_start) begin
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, in1};
      mplier_d = in2;
      acc_d    = '0;
    end else if (state_q == MUL) begin
      acc_d    = mul_final;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = mul_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Multiplier registers; operands are captured at accept so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`else
  assign mul_sel  = 1'b0;
  assign mul_load = 1'b0;
  assign mul_res  = '0;
  assign mul_cf   = 1'b0;
  assign busy     = 1'b0;
  assign in_ready = !rst && (!out_valid_q || out_ready);
`endif

  // Single-cycle operations; shifts carry the last bit shifted out via a guard bit
  always_comb begin
    add_full = {1'b0, in1} + {1'b0, in2};
    sub_full = {1'b0, in1} - {1'b0, in2};
    shl_full = {1'b0, in1} << shamt;
    shr_full = {in1, 1'b0} >> shamt;
    asr_full = $signed({in1, 1'b0}) >>> shamt;
    alu_res  = add_full[WIDTH-1:0];
    alu_cf   = add_full[WIDTH];
    alu_vf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_full[WIDTH-1] != in1[WIDTH-1]);
    case (sel)
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_cf  = sub_full[WIDTH];
        alu_vf  = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  begin alu_res = in1 & in2; alu_cf = 1'b0; alu_vf = 1'b0; end
      OP_OR:   begin alu_res = in1 | in2; alu_cf = 1'b0; alu_vf = 1'b0; end
      OP_NOT:  begin alu_res = ~in1;      alu_cf = 1'b0; alu_vf = 1'b0; end
      OP_XOR:  begin alu_res = in1 ^ in2; alu_cf = 1'b0; alu_vf = 1'b0; end
      OP_PASS: begin alu_res = in2;       alu_cf = 1'b0; alu_vf = 1'b0; end
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_cf  = shl_full[WIDTH];
        alu_vf  = 1'b0;
      end
      OP_SHR: begin
        alu_res = shr_full[WIDTH:1];
        alu_cf  = shr_full[0];
        alu_vf  = 1'b0;
      end
      OP_ASR: begin
        alu_res = asr_full[WIDTH:1];
        alu_cf  = asr_full[0];
        alu_vf  = 1'b0;
      end
      default: ;
    endcase
  end

  // Result register next-state: load wins over drain, otherwise hold while stalled
  always_comb begin
    res         = alu_res;
    res_cf      = alu_cf;
    res_vf      = alu_vf;
    out_d       = out_q;
    zf_d        = zf_q;
    nf_d        = nf_q;
    cf_d        = cf_q;
    vf_d        = vf_q;
    out_valid_d = out_valid_q;
    if (mul_load) begin
      res    = mul_res;
      res_cf = mul_cf;
      res_vf = 1'b0;
    end
    if (load_alu || mul_load) begin
      out_d       = res;
      zf_d        = (res == '0);
      nf_d        = res[WIDTH-1];
      cf_d        = res_cf;
      vf_d        = res_vf;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      cf_q        <= 1'b0;
      vf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      zf_q        <= zf_d;
      nf_q        <= nf_d;
      cf_q        <= cf_d;
      vf_q        <= vf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign zf        = zf_q;
  assign nf        = nf_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign out_valid = out_valid_q;

endmodule
